// File: rtl/tlul_host_req.sv
// tlul_host_req: single-outstanding TL-UL host adapter.
// Turns a local req/gnt command into one TL-UL A-channel request and reports
// the D-channel completion (or a timeout error) as a registered rvalid pulse.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_i/gnt_o               local command handshake (gnt_o is a 1-cycle pulse)
//   we_i, addr_i, wdata_i, be_i  command fields, captured on grant
//   rvalid_o, rdata_o, err_o  completion pulse with read data and error flag
//   unexp_o                   pulse for a dropped unsolicited D beat
//   busy_o                    a transaction is in flight
//   tl_o / tl_i               TL-UL host-to-device / device-to-host buses

package top_pkg;
    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
endpackage

package tlul_pkg;
    // A-channel opcodes
    localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] GET              = 3'h4;
    // D-channel opcodes
    localparam logic [2:0] ACCESS_ACK       = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic                         a_valid;
        logic [2:0]                   a_opcode;
        logic [2:0]                   a_param;
        logic [top_pkg::TL_SZW-1:0]   a_size;
        logic [top_pkg::TL_AIW-1:0]   a_source;
        logic [top_pkg::TL_AW-1:0]    a_address;
        logic [top_pkg::TL_DBW-1:0]   a_mask;
        logic [top_pkg::TL_DW-1:0]    a_data;
        logic                         d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                         d_valid;
        logic [2:0]                   d_opcode;
        logic [2:0]                   d_param;
        logic [top_pkg::TL_SZW-1:0]   d_size;
        logic [top_pkg::TL_AIW-1:0]   d_source;
        logic [top_pkg::TL_DIW-1:0]   d_sink;
        logic [top_pkg::TL_DW-1:0]    d_data;
        logic                         d_error;
        logic                         a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_req
    import tlul_pkg::*;
#(
    parameter logic [top_pkg::TL_AIW-1:0] SOURCE_ID      = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [top_pkg::TL_AW-1:0]    addr_i,
    input  logic [top_pkg::TL_DW-1:0]    wdata_i,
    input  logic [top_pkg::TL_DBW-1:0]   be_i,
    output logic                         rvalid_o,
    output logic [top_pkg::TL_DW-1:0]    rdata_o,
    output logic                         err_o,
    output logic                         unexp_o,
    output logic                         busy_o,
    output tl_h2d_t                      tl_o,
    input  tl_d2h_t                      tl_i
);

    localparam int unsigned AW    = top_pkg::TL_AW;
    localparam int unsigned DW    = top_pkg::TL_DW;
    localparam int unsigned DBW   = top_pkg::TL_DBW;
    localparam int unsigned SZW   = top_pkg::TL_SZW;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Captured command; the low address bits are dropped (word aligned)
    logic            we_q;
    logic [AW-3:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DBW-1:0]  be_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            load;
    logic            gnt_d, rvalid_d, err_d, unexp_d;
    logic [DW-1:0]   rdata_d;

    logic            a_hs;
    logic            timeout;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;

    // D-channel fields this host never looks at
    logic unused_inputs;
    assign unused_inputs = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, addr_i[1:0]};

    assign a_hs    = (state_q == S_REQ) && tl_i.a_ready;
    assign timeout = (cnt_q == TIMEOUT);

    // Response check: Get must see AccessAckData, Put must see AccessAck
    assign rsp_err  = tl_i.d_error
                    | (tl_i.d_source != SOURCE_ID)
                    | (we_q ? (tl_i.d_opcode != ACCESS_ACK)
                            : (tl_i.d_opcode != ACCESS_ACK_DATA));
    assign rsp_data = we_q ? '0 : tl_i.d_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) state_d = S_REQ;
            end
            S_REQ: begin
                // a D beat on the handshake cycle completes without visiting RSP
                if (a_hs) state_d = tl_i.d_valid ? S_IDLE : S_RSP;
            end
            S_RSP: begin
                if (tl_i.d_valid || timeout) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_d    = 1'b0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        unexp_d  = 1'b0;
        load     = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                gnt_d   = req_i;
                load    = req_i;
                unexp_d = tl_i.d_valid;
            end
            S_REQ: begin
                if (a_hs) begin
                    cnt_d = '0;
                    if (tl_i.d_valid) begin
                        rvalid_d = 1'b1;
                        err_d    = rsp_err;
                        rdata_d  = rsp_data;
                    end
                end else begin
                    unexp_d = tl_i.d_valid;
                end
            end
            S_RSP: begin
                // a beat arriving on the timeout cycle wins over the timeout
                if (tl_i.d_valid) begin
                    rvalid_d = 1'b1;
                    err_d    = rsp_err;
                    rdata_d  = rsp_data;
                end else if (timeout) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, command capture and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_o    <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            unexp_o  <= 1'b0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            gnt_o    <= gnt_d;
            rvalid_o <= rvalid_d;
            err_o    <= err_d;
            rdata_o  <= rdata_d;
            unexp_o  <= unexp_d;
            cnt_q    <= cnt_d;
            if (load) begin
                we_q    <= we_i;
                addr_q  <= addr_i[AW-1:2];
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

    // A channel is driven purely from captured fields, so it is stable under backpressure
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state_q == S_REQ);
        tl_o.a_opcode  = !we_q          ? GET :
                         (be_q == '1)   ? PUT_FULL_DATA : PUT_PARTIAL_DATA;
        tl_o.a_param   = '0;
        tl_o.a_size    = SZW'(2);
        tl_o.a_source  = SOURCE_ID;
        tl_o.a_address = {addr_q, 2'b00};
        tl_o.a_mask    = be_q;
        tl_o.a_data    = we_q ? wdata_q : '0;
        tl_o.d_ready   = !rst;
    end

endmodule

// File: tb/tb_tlul_host_req.sv
// Testbench for tlul_host_req: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_tlul_host_req;
    import tlul_pkg::*;

    localparam logic [7:0] SRC = 8'h05;
    localparam int         TO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err, unexp, busy;
    logic [31:0] rdata;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    int vectors = 0;
    int miscompares = 0;

    tlul_host_req #(.SOURCE_ID(SRC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .unexp_o(unexp), .busy_o(busy),
        .tl_o(tl_h), .tl_i(tl_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t q[$];          // outstanding command (at most one)
    bit   sent;          // its A beat has been accepted
    int   cyc = 0;
    int   hs_cyc = 0;    // cycle of the A handshake

    bit          e_gnt, e_rvalid, e_err, e_unexp;
    logic [31:0] e_rdata;

    function automatic logic [2:0] exp_opcode(txn_t t);
        if (!t.we) return 3'h4;
        return (t.be == 4'hF) ? 3'h0 : 3'h1;
    endfunction

    function automatic bit exp_rsp_err(txn_t t);
        logic [2:0] want;
        want = t.we ? 3'h0 : 3'h1;
        return tl_d.d_error || (tl_d.d_source != SRC) || (tl_d.d_opcode != want);
    endfunction

    function void finish_normal();
        e_rvalid = 1;
        e_err    = exp_rsp_err(q[0]);
        e_rdata  = q[0].we ? 32'h0 : tl_d.d_data;
        q.delete();
    endfunction

    always @(posedge clk) begin
        txn_t t;
        e_gnt = 0; e_rvalid = 0; e_err = 0; e_unexp = 0; e_rdata = '0;
        cyc++;
        if (rst) begin
            q.delete();
            sent = 0;
        end else if (q.size() == 0) begin
            if (tl_d.d_valid) e_unexp = 1;
            if (req) begin
                t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
                q.push_back(t);
                sent  = 0;
                e_gnt = 1;
            end
        end else if (!sent) begin
            if (tl_d.a_ready) begin
                if (tl_d.d_valid) finish_normal();
                else begin sent = 1; hs_cyc = cyc; end
            end else if (tl_d.d_valid) begin
                e_unexp = 1;
            end
        end else begin
            if (tl_d.d_valid) finish_normal();
            else if (cyc == hs_cyc + TO + 1) begin
                e_rvalid = 1; e_err = 1; e_rdata = '0;
                q.delete();
            end
        end
        #1;
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("rvalid", 64'(rvalid), 64'(e_rvalid));
        chk("unexp", 64'(unexp), 64'(e_unexp));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("d_ready", 64'(tl_h.d_ready), 64'(!rst));
        if (e_rvalid) begin
            chk("err", 64'(err), 64'(e_err));
            chk("rdata", 64'(rdata), 64'(e_rdata));
        end
        chk("a_valid", 64'(tl_h.a_valid), 64'(q.size() != 0 && !sent));
        if (q.size() != 0 && !sent) begin
            t = q[0];
            chk("a_opcode", 64'(tl_h.a_opcode), 64'(exp_opcode(t)));
            chk("a_address", 64'(tl_h.a_address), 64'({t.addr[31:2], 2'b00}));
            chk("a_mask", 64'(tl_h.a_mask), 64'(t.be));
            chk("a_data", 64'(tl_h.a_data), 64'(t.we ? t.wdata : 32'h0));
            chk("a_size", 64'(tl_h.a_size), 64'(2));
            chk("a_source", 64'(tl_h.a_source), 64'(SRC));
            chk("a_param", 64'(tl_h.a_param), 64'(0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic d_beat(input logic [2:0] op, input logic [7:0] src,
                          input logic e, input logic [31:0] data);
        tl_d.d_valid  = 1'b1;
        tl_d.d_opcode = op;
        tl_d.d_source = src;
        tl_d.d_error  = e;
        tl_d.d_data   = data;
    endtask

    task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    initial begin
        int dprob;
        int n;
        bit seen;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        tl_d = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_d_ready", 64'(tl_h.d_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_a_valid", 64'(tl_h.a_valid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("d_ready_up", 64'(tl_h.d_ready), 64'(1));

        // read, response one cycle after the handshake
        cmd(1'b0, 32'h1003, 32'hCAFE0000, 4'hF);
        @(negedge clk);
        chk("rd_gnt", 64'(gnt), 64'(1));
        chk("rd_addr", 64'(tl_h.a_address), 64'h1000);
        chk("rd_op", 64'(tl_h.a_opcode), 64'(3'h4));
        req = 1'b0; tl_d.a_ready = 1'b1;
        @(negedge clk);
        chk("rd_wait_busy", 64'(busy), 64'(1));
        tl_d.a_ready = 1'b0;
        d_beat(3'h1, SRC, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_rvalid", 64'(rvalid), 64'(1));
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("rd_err", 64'(err), 64'(0));
        tl_d.d_valid = 1'b0;
        @(negedge clk);
        chk("rd_pulse", 64'(rvalid), 64'(0));

        // full write, D beat on the handshake cycle
        cmd(1'b1, 32'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("wf_op", 64'(tl_h.a_opcode), 64'(3'h0));
        chk("wf_data", 64'(tl_h.a_data), 64'h12345678);
        req = 1'b0; tl_d.a_ready = 1'b1;
        d_beat(3'h0, SRC, 1'b0, 32'h55);
        @(negedge clk);
        chk("wf_rvalid", 64'(rvalid), 64'(1));
        chk("wf_err", 64'(err), 64'(0));
        chk("wf_busy", 64'(busy), 64'(0));
        tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b0;

        // partial write answered with the wrong opcode
        cmd(1'b1, 32'h44, 32'hA1B2C3D4, 4'h3);
        @(negedge clk);
        chk("wp_op", 64'(tl_h.a_opcode), 64'(3'h1));
        chk("wp_mask", 64'(tl_h.a_mask), 64'(4'h3));
        req = 1'b0; tl_d.a_ready = 1'b1;
        @(negedge clk);
        tl_d.a_ready = 1'b0;
        d_beat(3'h1, SRC, 1'b0, 32'h0);
        @(negedge clk);
        chk("wp_err", 64'(err), 64'(1));
        tl_d.d_valid = 1'b0;

        // backpressure with a late request, then wrong source id
        cmd(1'b0, 32'h2008, 32'h0, 4'hF);
        @(negedge clk);
        addr = 32'hFFFF0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_gnt", 64'(gnt), 64'(0));
            chk("bp_a_valid", 64'(tl_h.a_valid), 64'(1));
            chk("bp_addr", 64'(tl_h.a_address), 64'h2008);
        end
        req = 1'b0; tl_d.a_ready = 1'b1;
        @(negedge clk);
        tl_d.a_ready = 1'b0;
        d_beat(3'h1, 8'(SRC + 8'd1), 1'b0, 32'h1);
        @(negedge clk);
        chk("src_err", 64'(err), 64'(1));
        tl_d.d_valid = 1'b0;

        // AccessAck for a Get, then d_error
        for (int c = 0; c < 2; c++) begin
            cmd(1'b0, 32'h100, 32'h0, 4'hF);
            @(negedge clk);
            req = 1'b0; tl_d.a_ready = 1'b1;
            @(negedge clk);
            tl_d.a_ready = 1'b0;
            d_beat((c == 0) ? 3'h0 : 3'h1, SRC, (c == 1), 32'h77);
            @(negedge clk);
            chk("mis_err", 64'(err), 64'(1));
            chk("mis_rvalid", 64'(rvalid), 64'(1));
            tl_d.d_valid = 1'b0;
        end

        // timeout, then a stray beat
        cmd(1'b0, 32'h3000, 32'h0, 4'hF);
        @(negedge clk);
        req = 1'b0; tl_d.a_ready = 1'b1;
        @(negedge clk);
        tl_d.a_ready = 1'b0;
        n = 0; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (rvalid === 1'b1) begin seen = 1; n = k; end
        end
        chk("to_latency", 64'(n), 64'(9));
        chk("to_err", 64'(err), 64'(1));
        chk("to_rdata", 64'(rdata), 64'(0));
        d_beat(3'h1, SRC, 1'b0, 32'h9);
        @(negedge clk);
        chk("stray_unexp", 64'(unexp), 64'(1));
        chk("stray_rvalid", 64'(rvalid), 64'(0));
        tl_d.d_valid = 1'b0;

        // reset while waiting for the response
        cmd(1'b0, 32'h4000, 32'h0, 4'hF);
        @(negedge clk);
        req = 1'b0; tl_d.a_ready = 1'b1;
        @(negedge clk);
        tl_d.a_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_rvalid", 64'(rvalid), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        cmd(1'b0, 32'h4004, 32'h0, 4'hF);
        @(negedge clk);
        chk("mr_gnt", 64'(gnt), 64'(1));
        req = 1'b0; tl_d.a_ready = 1'b1;
        d_beat(3'h1, SRC, 1'b0, 32'hA5A5A5A5);
        @(negedge clk);
        chk("mr_rvalid2", 64'(rvalid), 64'(1));
        chk("mr_rdata", 64'(rdata), 64'hA5A5A5A5);
        chk("mr_err2", 64'(err), 64'(0));
        tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b0;

        // randomized traffic; sparse D phases exercise the timeout
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            dprob = ((i / 500) % 2 == 0) ? 15 : 3;
            rst   = ($urandom_range(149) == 0);
            req   = ($urandom_range(2) == 0);
            we    = 1'($urandom_range(1));
            addr  = $urandom;
            wdata = $urandom;
            be    = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
            tl_d.a_ready  = ($urandom_range(1) == 0);
            tl_d.d_valid  = ($urandom_range(99) < dprob);
            tl_d.d_opcode = ($urandom_range(9) == 0) ? 3'($urandom) : 3'($urandom_range(1));
            tl_d.d_source = ($urandom_range(9) == 0) ? 8'(SRC + 8'd1) : SRC;
            tl_d.d_error  = ($urandom_range(9) == 0);
            tl_d.d_data   = $urandom;
            tl_d.d_param  = 3'($urandom);
            tl_d.d_size   = 2'($urandom);
            tl_d.d_sink   = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0; tl_d = '0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
